// File: rtl/fft_r2_pkg.sv
// Shared types and saturating helpers for the radix-2 SDF FFT stages.
// Helpers work in FW-bit signed arithmetic; callers pass the target width w.
package fft_r2_pkg;

    localparam int FW = 32;

    typedef enum logic {PH_A, PH_B} phase_t;
    typedef enum logic {ST_IDLE, ST_DRAIN} st_t;

    function automatic logic signed [FW-1:0] sat_w(input logic signed [FW-1:0] x, input int w);
        logic signed [FW-1:0] hi, lo;
        hi = (32'sd1 <<< (w - 1)) - 32'sd1;
        lo = -hi - 32'sd1;
        if (x > hi)      return hi;
        else if (x < lo) return lo;
        else             return x;
    endfunction

    // -x clamped to w bits, so the most negative code maps to the most positive
    function automatic logic signed [FW-1:0] sat_neg(input logic signed [FW-1:0] x, input int w);
        return sat_w(-x, w);
    endfunction

    function automatic logic signed [FW-1:0] rnd_half_sat(input logic signed [FW-1:0] x, input int w);
        return sat_w((x + 32'sd1) >>> 1, w);
    endfunction

endpackage

// File: rtl/fft_r2_dly_mem.sv
// Butterfly delay memory: DEPTH words of LANES complex samples, one write port
// and a combinational read port that returns the pre-write contents.
module fft_r2_dly_mem
    import fft_r2_pkg::*;
#(
    parameter int DW    = 11,
    parameter int LANES = 16,
    parameter int DEPTH = 8,
    parameter int AW    = 3
) (
    input  logic                      clk,
    input  logic                      we,
    input  logic [AW-1:0]             waddr,
    input  logic [0:LANES-1][DW-1:0]  wr_re,
    input  logic [0:LANES-1][DW-1:0]  wr_im,
    input  logic [AW-1:0]             raddr,
    output logic [0:LANES-1][DW-1:0]  rd_re,
    output logic [0:LANES-1][DW-1:0]  rd_im
);

    logic [0:LANES-1][DW-1:0] mem_re [DEPTH];
    logic [0:LANES-1][DW-1:0] mem_im [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_re[waddr] <= wr_re;
            mem_im[waddr] <= wr_im;
        end
    end

    assign rd_re = mem_re[raddr];
    assign rd_im = mem_im[raddr];

endmodule

// File: rtl/fft_r2_sdf_stage.sv
// Radix-2 DIF single-delay-feedback butterfly stage: first half is buffered,
// sums stream out with the second half, differences drain from the same memory.
module fft_r2_sdf_stage
    import fft_r2_pkg::*;
#(
    parameter  int WIDTH    = 10,
    parameter  int LANES    = 16,
    parameter  int HALF_CYC = 8,
    parameter  int SCALE    = 0,
    localparam int OW       = WIDTH + 1 - SCALE,
    localparam int AW       = (HALF_CYC > 1) ? $clog2(HALF_CYC) : 1
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         din_valid,
    input  logic [0:LANES-1][WIDTH-1:0]  din_re,
    input  logic [0:LANES-1][WIDTH-1:0]  din_im,
    input  logic                         conj_in,
    output logic                         dout_valid,
    output logic [0:LANES-1][OW-1:0]     dout_re,
    output logic [0:LANES-1][OW-1:0]     dout_im,
    output logic                         dout_is_diff,
    output logic [AW-1:0]                dout_idx
);

    localparam int MW = WIDTH + 1;
    localparam int CW = $clog2(2 * HALF_CYC);

    logic [CW-1:0] in_cnt;
    logic          conj_q, conj_eff;
    phase_t        ph;
    st_t           state_q, state_d;
    logic [AW-1:0] dptr_q, dptr_d, beat_k, rd_addr;
    logic          last_beat, drain, sum_beat;

    logic [0:LANES-1][MW-1:0] wr_re, wr_im, rd_re, rd_im;
    logic [0:LANES-1][OW-1:0] o_re, o_im;

    function automatic logic [OW-1:0] to_out(input logic signed [MW-1:0] x);
        return OW'((SCALE != 0) ? rnd_half_sat(FW'(x), OW) : FW'(x));
    endfunction

    // 2*HALF_CYC is a power of two, so the counter MSB is the phase bit
    assign ph        = in_cnt[CW-1] ? PH_B : PH_A;
    assign beat_k    = (HALF_CYC == 1) ? '0 : in_cnt[AW-1:0];
    assign last_beat = (in_cnt == CW'(2 * HALF_CYC - 1));
    assign conj_eff  = (in_cnt == '0) ? conj_in : conj_q;
    assign drain     = (state_q == ST_DRAIN);
    assign sum_beat  = din_valid && (ph == PH_B);
    // Phase B and drain never overlap, so one read port serves both
    assign rd_addr   = drain ? dptr_q : beat_k;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_cnt  <= '0;
            conj_q  <= 1'b0;
            state_q <= ST_IDLE;
            dptr_q  <= '0;
        end else begin
            state_q <= state_d;
            dptr_q  <= dptr_d;
            if (din_valid) begin
                in_cnt <= in_cnt + CW'(1);
                if (in_cnt == '0)
                    conj_q <= conj_in;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        dptr_d  = dptr_q;
        case (state_q)
            ST_IDLE: begin
                if (din_valid && last_beat)
                    state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (dptr_q == AW'(HALF_CYC - 1)) begin
                    state_d = ST_IDLE;
                    dptr_d  = '0;
                end else begin
                    dptr_d  = dptr_q + AW'(1);
                end
            end
            default: begin
                state_d = ST_IDLE;
                dptr_d  = '0;
            end
        endcase
    end

    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic signed [WIDTH-1:0] b_re, b_im;
        logic signed [MW-1:0]    a_re, a_im, s_re, s_im, d_re, d_im;

        assign b_re = din_re[l];
        assign b_im = conj_eff ? WIDTH'(sat_neg(FW'(signed'(din_im[l])), WIDTH)) : din_im[l];

        assign a_re = rd_re[l];
        assign a_im = rd_im[l];
        assign s_re = a_re + MW'(b_re);
        assign s_im = a_im + MW'(b_im);
        assign d_re = a_re - MW'(b_re);
        assign d_im = a_im - MW'(b_im);

        assign wr_re[l] = (ph == PH_A) ? MW'(b_re) : d_re;
        assign wr_im[l] = (ph == PH_A) ? MW'(b_im) : d_im;

        // During drain the read port carries the stored difference
        assign o_re[l] = drain ? to_out(a_re) : to_out(s_re);
        assign o_im[l] = drain ? to_out(a_im) : to_out(s_im);
    end

    fft_r2_dly_mem #(
        .DW    (MW),
        .LANES (LANES),
        .DEPTH (HALF_CYC),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (din_valid),
        .waddr (beat_k),
        .wr_re (wr_re),
        .wr_im (wr_im),
        .raddr (rd_addr),
        .rd_re (rd_re),
        .rd_im (rd_im)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            dout_valid   <= 1'b0;
            dout_is_diff <= 1'b0;
            dout_idx     <= '0;
            dout_re      <= '0;
            dout_im      <= '0;
        end else begin
            dout_valid <= drain || sum_beat;
            if (drain) begin
                dout_is_diff <= 1'b1;
                dout_idx     <= dptr_q;
                dout_re      <= o_re;
                dout_im      <= o_im;
            end else if (sum_beat) begin
                dout_is_diff <= 1'b0;
                dout_idx     <= beat_k;
                dout_re      <= o_re;
                dout_im      <= o_im;
            end
        end
    end

endmodule

// File: tb/tb_fft_r2_sdf_stage.sv
// Directed bench for the SDF butterfly stage: full-growth, scaled and
// HALF_CYC=1 instances share one stimulus stream.
module tb_fft_r2_sdf_stage;

    localparam int WIDTH = 10;
    localparam int LANES = 16;
    localparam int H     = 8;

    logic clk = 1'b0;
    logic rstn;
    logic din_valid, conj_in;
    logic [0:LANES-1][WIDTH-1:0] din_re, din_im;

    logic m_valid, m_diff;
    logic [2:0] m_idx;
    logic [0:LANES-1][WIDTH:0] m_re, m_im;

    logic s_valid, s_diff;
    logic [2:0] s_idx;
    logic [0:LANES-1][WIDTH-1:0] s_re, s_im;

    logic h_valid, h_diff;
    logic [0:0] h_idx;
    logic [0:LANES-1][WIDTH:0] h_re, h_im;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    fft_r2_sdf_stage #(.WIDTH(WIDTH), .LANES(LANES), .HALF_CYC(H), .SCALE(0)) dut_m (
        .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
        .conj_in(conj_in), .dout_valid(m_valid), .dout_re(m_re), .dout_im(m_im),
        .dout_is_diff(m_diff), .dout_idx(m_idx));

    fft_r2_sdf_stage #(.WIDTH(WIDTH), .LANES(LANES), .HALF_CYC(H), .SCALE(1)) dut_s (
        .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
        .conj_in(conj_in), .dout_valid(s_valid), .dout_re(s_re), .dout_im(s_im),
        .dout_is_diff(s_diff), .dout_idx(s_idx));

    fft_r2_sdf_stage #(.WIDTH(WIDTH), .LANES(LANES), .HALF_CYC(1), .SCALE(0)) dut_h (
        .clk(clk), .rstn(rstn), .din_valid(din_valid), .din_re(din_re), .din_im(din_im),
        .conj_in(conj_in), .dout_valid(h_valid), .dout_re(h_re), .dout_im(h_im),
        .dout_is_diff(h_diff), .dout_idx(h_idx));

    task automatic chk(input string tag, input int obs, input int exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // All lanes get im; re gets re + step*lane
    task automatic drive(input logic v, input int re, input int im, input int step);
        din_valid = v;
        for (int l = 0; l < LANES; l++) begin
            din_re[l] = WIDTH'(re + step * l);
            din_im[l] = WIDTH'(im);
        end
    endtask

    // One block (A then B), then a drain with din_valid low.
    // conj_in is cj on beat 0 and inverted afterwards, so it must be held.
    task automatic run_block(input int are, input int aim, input int bre, input int bim,
                             input logic cj, input logic gaps,
                             input int xs_re, input int xs_im, input int xd_re, input int xd_im,
                             input int ys_re, input int ys_im, input int yd_re, input int yd_im);
        for (int c = 0; c < 2 * H; c++) begin
            if (gaps) begin
                int n;
                n = $urandom_range(0, 2);
                for (int g = 0; g < n; g++) begin
                    din_valid = 1'b0;
                    conj_in   = ~cj;
                    tick();
                    chk("gap_quiet", int'(m_valid), 0);
                end
            end
            conj_in = (c == 0) ? cj : ~cj;
            if (c < H) drive(1'b1, are, aim, 0);
            else       drive(1'b1, bre, bim, 0);
            tick();
            if (c < H) begin
                chk("a_quiet", int'(m_valid), 0);
            end else begin
                chk("sum_valid", int'(m_valid), 1);
                chk("sum_flag", int'(m_diff), 0);
                chk("sum_idx", int'(m_idx), c - H);
                chk("sum_re0", int'($signed(m_re[0])), xs_re);
                chk("sum_im15", int'($signed(m_im[LANES-1])), xs_im);
                chk("ssum_re0", int'($signed(s_re[0])), ys_re);
                chk("ssum_im0", int'($signed(s_im[0])), ys_im);
            end
        end
        din_valid = 1'b0;
        conj_in   = 1'b0;
        for (int d = 0; d < H; d++) begin
            tick();
            chk("dif_valid", int'(m_valid), 1);
            chk("dif_flag", int'(m_diff), 1);
            chk("dif_idx", int'(m_idx), d);
            chk("dif_re15", int'($signed(m_re[LANES-1])), xd_re);
            chk("dif_im0", int'($signed(m_im[0])), xd_im);
            chk("sdif_re0", int'($signed(s_re[0])), yd_re);
            chk("sdif_im0", int'($signed(s_im[0])), yd_im);
            chk("sdif_flag", int'(s_diff), 1);
        end
        tick();
        chk("post_quiet", int'(m_valid), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rstn = 1'b1;
        conj_in = 1'b0;
        drive(1'b0, 0, 0, 0);
        #2 rstn = 1'b0;
        tick();
        tick();
        chk("rst_valid", int'(m_valid), 0);
        chk("rst_flag", int'(m_diff), 0);
        chk("rst_idx", int'(m_idx), 0);
        chk("rst_re0", int'($signed(m_re[0])), 0);
        chk("rst_im15", int'($signed(m_im[LANES-1])), 0);
        chk("rst_svalid", int'(s_valid), 0);
        chk("rst_hvalid", int'(h_valid), 0);
        rstn = 1'b1;

        // Basic block
        run_block(100, -50, 20, 10, 1'b0, 1'b0, 120, -40, 80, -60, 60, -20, 40, -30);

        // Back-to-back blocks: block-1 drain overlaps block-2 Phase A
        conj_in = 1'b0;
        for (int c = 0; c < 4 * H; c++) begin
            int k;
            k = c % H;
            case (c / H)
                0:       drive(1'b1, 10 + k, 5, 1);
                1:       drive(1'b1, 3, -2, 0);
                2:       drive(1'b1, 40 + k, -k, 0);
                default: drive(1'b1, 1, 2, 0);
            endcase
            tick();
            if (c < H) begin
                chk("b2b_quiet", int'(m_valid), 0);
            end else begin
                chk("b2b_valid", int'(m_valid), 1);
                if (c < 2 * H) begin
                    chk("b2b_s1_flag", int'(m_diff), 0);
                    chk("b2b_s1_re0", int'($signed(m_re[0])), 13 + k);
                    chk("b2b_s1_re15", int'($signed(m_re[LANES-1])), 28 + k);
                    chk("b2b_s1_im0", int'($signed(m_im[0])), 3);
                end else if (c < 3 * H) begin
                    chk("b2b_d1_flag", int'(m_diff), 1);
                    chk("b2b_d1_idx", int'(m_idx), k);
                    chk("b2b_d1_re0", int'($signed(m_re[0])), 7 + k);
                    chk("b2b_d1_re15", int'($signed(m_re[LANES-1])), 22 + k);
                    chk("b2b_d1_im0", int'($signed(m_im[0])), 7);
                end else begin
                    chk("b2b_s2_flag", int'(m_diff), 0);
                    chk("b2b_s2_re0", int'($signed(m_re[0])), 41 + k);
                    chk("b2b_s2_im0", int'($signed(m_im[0])), 2 - k);
                end
            end
        end
        din_valid = 1'b0;
        for (int d = 0; d < H; d++) begin
            tick();
            chk("b2b_d2_valid", int'(m_valid), 1);
            chk("b2b_d2_idx", int'(m_idx), d);
            chk("b2b_d2_re0", int'($signed(m_re[0])), 39 + d);
            chk("b2b_d2_im0", int'($signed(m_im[0])), -d - 2);
        end
        tick();
        chk("b2b_end_quiet", int'(m_valid), 0);

        // Extremes: exact growth at full width, round/saturate when scaled
        run_block(511, -512, -512, -512, 1'b0, 1'b0, -1, -1024, 1023, 0, 0, -512, 511, 0);

        // Conjugate mode: -512 saturates to 511, -511 becomes 511
        run_block(0, -512, 0, -511, 1'b1, 1'b0, 0, 1022, 0, 0, 0, 511, 0, 0);

        // Random input gaps give the same results as the gapless block
        run_block(100, -50, 20, 10, 1'b0, 1'b1, 120, -40, 80, -60, 60, -20, 40, -30);

        // Reset in the middle of Phase B
        for (int c = 0; c < H + 4; c++) begin
            if (c < H) drive(1'b1, 7, 7, 0);
            else       drive(1'b1, 9, -9, 0);
            tick();
        end
        drive(1'b1, 9, -9, 0);
        #3 rstn = 1'b0;
        #1;
        chk("mid_rst_valid", int'(m_valid), 0);
        chk("mid_rst_idx", int'(m_idx), 0);
        chk("mid_rst_re0", int'($signed(m_re[0])), 0);
        chk("mid_rst_sre0", int'($signed(s_re[0])), 0);
        din_valid = 1'b0;
        tick();
        rstn = 1'b1;
        run_block(1, 1, 1, 1, 1'b0, 1'b0, 2, 2, 0, 0, 1, 1, 0, 0);

        // HALF_CYC=1 instance: two back-to-back two-beat blocks
        rstn = 1'b0;
        tick();
        rstn = 1'b1;
        conj_in = 1'b0;
        drive(1'b1, 3, 3, 0);
        tick();
        chk("h1_a_quiet", int'(h_valid), 0);
        drive(1'b1, 1, 1, 0);
        tick();
        chk("h1_s1_valid", int'(h_valid), 1);
        chk("h1_s1_flag", int'(h_diff), 0);
        chk("h1_s1_re0", int'($signed(h_re[0])), 4);
        chk("h1_s1_im15", int'($signed(h_im[LANES-1])), 4);
        drive(1'b1, 5, 5, 0);
        tick();
        chk("h1_d1_valid", int'(h_valid), 1);
        chk("h1_d1_flag", int'(h_diff), 1);
        chk("h1_d1_re0", int'($signed(h_re[0])), 2);
        drive(1'b1, 2, 2, 0);
        tick();
        chk("h1_s2_flag", int'(h_diff), 0);
        chk("h1_s2_re0", int'($signed(h_re[0])), 7);
        din_valid = 1'b0;
        tick();
        chk("h1_d2_valid", int'(h_valid), 1);
        chk("h1_d2_flag", int'(h_diff), 1);
        chk("h1_d2_im0", int'($signed(h_im[0])), 3);
        chk("h1_d2_idx", int'(h_idx), 0);
        tick();
        chk("h1_end_quiet", int'(h_valid), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
